// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and sweep-clear state encoding for the register file
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  typedef enum logic [1:0] {CLR_IDLE, CLR_SWEEP, CLR_DONE} clr_state_t;
endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: sweep-clear sequencer walking every register address once
//  clk_i          clock
//  rst_ni         synchronous active-low reset
//  clr_req_i      start a sweep, honoured only when idle
//  sweep_en_o     zero the register at sweep_addr_o this cycle
//  sweep_addr_o   register being cleared
//  clr_busy_o     sweep in progress
//  clr_done_o     single-cycle completion pulse
//  pend_clr_all_o wipe every pending bit at this edge
module regfile_clr_seq import regfile_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_req_i,
  output logic              sweep_en_o,
  output logic [ADDR_W-1:0] sweep_addr_o,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              pend_clr_all_o
);
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
  clr_state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = (state_q == CLR_IDLE && clr_req_i) ? CLR_SWEEP :
              (state_q == CLR_SWEEP && cnt_q == LAST) ? CLR_DONE :
              (state_q == CLR_DONE) ? CLR_IDLE : state_q;
    cnt_d = (state_q == CLR_SWEEP && cnt_q != LAST) ? cnt_q + ADDR_W'(1) : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign sweep_en_o     = state_q == CLR_SWEEP;
  assign sweep_addr_o   = cnt_q;
  assign clr_busy_o     = state_q == CLR_SWEEP;
  assign clr_done_o     = state_q == CLR_DONE;
  assign pend_clr_all_o = state_q == CLR_IDLE && clr_req_i;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass, pending scoreboard and sweep clear
//  clk_i, rst_ni          clock, synchronous active-low reset
//  rd_addr_i / rd_data_o  NUM_RD packed async read ports
//  rd_pend_o              pending bit per read address
//  wa_* / wb_*            write ports A (ALU) and B (memory); B wins on collision
//  pend_set_i/pend_addr_i mark a register as awaiting a producer
//  clr_req_i              start a sweep clear
//  clr_busy_o/clr_done_o  sweep status and completion pulse
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_pend_o,
  input  logic                     wa_en_i,
  input  logic [ADDR_W-1:0]        wa_addr_i,
  input  logic [DATA_W-1:0]        wa_data_i,
  input  logic                     wb_en_i,
  input  logic [ADDR_W-1:0]        wb_addr_i,
  input  logic [DATA_W-1:0]        wb_data_i,
  input  logic                     pend_set_i,
  input  logic [ADDR_W-1:0]        pend_addr_i,
  input  logic                     clr_req_i,
  output logic                     clr_busy_o,
  output logic                     clr_done_o
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] arr_q [DEPTH];
  logic [DATA_W-1:0] arr_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              sweep_en, pend_clr_all, wa_acc, wb_acc, ps_acc;
  logic [ADDR_W-1:0] sweep_addr;
  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clr_req_i      (clr_req_i),
    .sweep_en_o     (sweep_en),
    .sweep_addr_o   (sweep_addr),
    .clr_busy_o     (clr_busy_o),
    .clr_done_o     (clr_done_o),
    .pend_clr_all_o (pend_clr_all)
  );
  // Writes and pend_set are dropped while sweeping; the caller stalls.
  assign wa_acc = wa_en_i && !clr_busy_o && !(ZERO_REG != 0 && wa_addr_i == '0);
  assign wb_acc = wb_en_i && !clr_busy_o && !(ZERO_REG != 0 && wb_addr_i == '0);
  assign ps_acc = pend_set_i && !clr_busy_o && !(ZERO_REG != 0 && pend_addr_i == '0);
  always_comb begin
    arr_d = arr_q;
    if (wa_acc) arr_d[wa_addr_i] = wa_data_i;
    if (wb_acc) arr_d[wb_addr_i] = wb_data_i;
    if (sweep_en) arr_d[sweep_addr] = '0;
    pend_d = pend_q;
    if (wa_acc) pend_d[wa_addr_i] = 1'b0;
    if (wb_acc) pend_d[wb_addr_i] = 1'b0;
    // A new producer claimed in the same cycle as a writeback keeps the bit set.
    if (ps_acc) pend_d[pend_addr_i] = 1'b1;
    if (pend_clr_all) pend_d = '0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      arr_q  <= '{default: '0};
      pend_q <= '0;
    end else begin
      arr_q  <= arr_d;
      pend_q <= pend_d;
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic z, hb, ha;
    assign a  = rd_addr_i[i*ADDR_W +: ADDR_W];
    assign z  = ZERO_REG != 0 && a == '0;
    assign hb = BYPASS != 0 && wb_acc && wb_addr_i == a;
    assign ha = BYPASS != 0 && wa_acc && wa_addr_i == a;
    assign rd_data_o[i*DATA_W +: DATA_W] = z ? '0 : hb ? wb_data_i : ha ? wa_data_i : arr_q[a];
    assign rd_pend_o[i] = !z && !hb && !ha && pend_q[a];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (bypass and non-bypass builds)
module tb_regfile_mp;
  logic        clk = 0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_pend, rd_pend_nb;
  logic        wa_en, wb_en, pend_set, clr_req;
  logic [4:0]  wa_addr, wb_addr, pend_addr;
  logic [31:0] wa_data, wb_data;
  logic        clr_busy, clr_done, clr_busy_nb, clr_done_nb;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_pend_o(rd_pend),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .pend_set_i(pend_set), .pend_addr_i(pend_addr), .clr_req_i(clr_req),
    .clr_busy_o(clr_busy), .clr_done_o(clr_done)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .rd_pend_o(rd_pend_nb),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .pend_set_i(pend_set), .pend_addr_i(pend_addr), .clr_req_i(clr_req),
    .clr_busy_o(clr_busy_nb), .clr_done_o(clr_done_nb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wa_en = 0; wb_en = 0; pend_set = 0; clr_req = 0;
    wa_addr = 0; wb_addr = 0; pend_addr = 0; wa_data = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    wa_en = 1; wa_addr = 5; wa_data = 32'h1234;
    pend_set = 1; pend_addr = 6;
    step();
    idle_inputs();
    rd_addr = {5'd6, 5'd5};
    #1;
    tests++;
    if (rd_data[31:0] !== 32'h1234) begin
      fails++; $display("FAIL reset_preload: got %h want %h", rd_data[31:0], 32'h1234);
    end
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
    tests++;
    if (rd_data !== 64'h0) begin
      fails++; $display("FAIL reset_data: got %h want 0", rd_data);
    end
    tests++;
    if (rd_pend !== 2'b00 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      fails++; $display("FAIL reset_status: pend %b busy %b done %b want 00 0 0", rd_pend, clr_busy, clr_done);
    end
  endtask

  task automatic test_write_bypass();
    rd_addr = {5'd0, 5'd3};
    wa_en = 1; wa_addr = 3; wa_data = 32'hAAAA_0001;
    #1;
    tests++;
    if (rd_data[31:0] !== 32'hAAAA_0001) begin
      fails++; $display("FAIL bypass_same_cycle: got %h want %h", rd_data[31:0], 32'hAAAA_0001);
    end
    tests++;
    if (rd_data_nb[31:0] !== 32'h0) begin
      fails++; $display("FAIL nobypass_same_cycle: got %h want 0", rd_data_nb[31:0]);
    end
    step();
    idle_inputs();
    #1;
    tests++;
    if (rd_data[31:0] !== 32'hAAAA_0001 || rd_data_nb[31:0] !== 32'hAAAA_0001) begin
      fails++; $display("FAIL write_after_edge: got %h/%h want %h", rd_data[31:0], rd_data_nb[31:0], 32'hAAAA_0001);
    end
  endtask

  task automatic test_port_conflict();
    rd_addr = {5'd0, 5'd7};
    wa_en = 1; wa_addr = 7; wa_data = 32'h11;
    wb_en = 1; wb_addr = 7; wb_data = 32'h22;
    #1;
    tests++;
    if (rd_data[31:0] !== 32'h22) begin
      fails++; $display("FAIL conflict_bypass: got %h want 22", rd_data[31:0]);
    end
    step();
    idle_inputs();
    #1;
    tests++;
    if (rd_data[31:0] !== 32'h22 || rd_data_nb[31:0] !== 32'h22) begin
      fails++; $display("FAIL conflict_b_wins: got %h/%h want 22", rd_data[31:0], rd_data_nb[31:0]);
    end
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF_FFFF;
    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    rd_addr = {5'd0, 5'd0};
    #1;
    tests++;
    if (rd_data !== 64'h0) begin
      fails++; $display("FAIL r0_bypass: got %h want 0", rd_data);
    end
    step();
    idle_inputs();
    #1;
    tests++;
    if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
      fails++; $display("FAIL r0_write: got %h/%h want 0", rd_data, rd_data_nb);
    end
  endtask

  task automatic test_scoreboard();
    rd_addr = {5'd0, 5'd9};
    pend_set = 1; pend_addr = 9;
    step();
    idle_inputs();
    #1;
    tests++;
    if (rd_pend[0] !== 1'b1) begin
      fails++; $display("FAIL pend_set: got %b want 1", rd_pend[0]);
    end
    wb_en = 1; wb_addr = 9; wb_data = 32'h99;
    #1;
    tests++;
    if (rd_pend[0] !== 1'b0 || rd_pend_nb[0] !== 1'b1) begin
      fails++; $display("FAIL pend_wb_same_cycle: got %b/%b want 0/1", rd_pend[0], rd_pend_nb[0]);
    end
    step();
    idle_inputs();
    #1;
    tests++;
    if (rd_pend[0] !== 1'b0 || rd_pend_nb[0] !== 1'b0 || rd_data[31:0] !== 32'h99) begin
      fails++; $display("FAIL pend_cleared: got %b/%b data %h want 0/0 99", rd_pend[0], rd_pend_nb[0], rd_data[31:0]);
    end
    pend_set = 1; pend_addr = 9;
    wa_en = 1; wa_addr = 9; wa_data = 32'h55;
    step();
    idle_inputs();
    #1;
    tests++;
    if (rd_pend[0] !== 1'b1 || rd_data[31:0] !== 32'h55) begin
      fails++; $display("FAIL pend_set_wins: got %b data %h want 1 55", rd_pend[0], rd_data[31:0]);
    end
    pend_set = 1; pend_addr = 0;
    step();
    idle_inputs();
    #1;
    tests++;
    if (rd_pend[1] !== 1'b0) begin
      fails++; $display("FAIL pend_r0: got %b want 0", rd_pend[1]);
    end
  endtask

  task automatic test_sweep();
    int bad;
    for (int r = 1; r < 32; r++) begin
      wa_en = 1; wa_addr = 5'(r); wa_data = 32'(r);
      step();
    end
    idle_inputs();
    pend_set = 1; pend_addr = 12;
    step();
    idle_inputs();
    rd_addr = {5'd12, 5'd17};
    #1;
    tests++;
    if (rd_data[31:0] !== 32'd17 || rd_pend[1] !== 1'b1) begin
      fails++; $display("FAIL fill: got %h pend %b want 11 1", rd_data[31:0], rd_pend[1]);
    end
    clr_req = 1;
    step();
    clr_req = 0;
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (clr_busy !== 1'b1 || clr_done !== 1'b0) bad++;
      if (k == 5) begin
        rd_addr = {5'd12, 5'd1};
        wa_en = 1; wa_addr = 1; wa_data = 32'hDEAD;
        pend_set = 1; pend_addr = 12;
        #1;
        tests++;
        if (rd_data[31:0] !== 32'h0 || rd_pend[1] !== 1'b0) begin
          fails++; $display("FAIL sweep_read: got %h pend %b want 0 0", rd_data[31:0], rd_pend[1]);
        end
      end
      step();
      idle_inputs();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL sweep_busy: %0d bad cycles want 0", bad);
    end
    tests++;
    if (clr_done !== 1'b1 || clr_busy !== 1'b0) begin
      fails++; $display("FAIL sweep_done: done %b busy %b want 1 0", clr_done, clr_busy);
    end
    step();
    tests++;
    if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
      fails++; $display("FAIL done_pulse: done %b busy %b want 0 0", clr_done, clr_busy);
    end
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      rd_addr = {5'd0, 5'(r)};
      #1;
      if (rd_data[31:0] !== 32'h0 || rd_pend[0] !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL sweep_cleared: %0d nonzero regs want 0", bad);
    end
  endtask

  task automatic test_sweep_reset();
    int bad;
    wa_en = 1; wa_addr = 30; wa_data = 32'h3030;
    step();
    idle_inputs();
    clr_req = 1;
    step();
    clr_req = 0;
    for (int k = 1; k < 10; k++) step();
    tests++;
    if (clr_busy !== 1'b1) begin
      fails++; $display("FAIL sweep2_busy: got %b want 1", clr_busy);
    end
    rst_n = 0;
    step();
    rst_n = 1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (clr_busy !== 1'b0 || clr_done !== 1'b0) bad++;
      step();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL sweep_abort: %0d cycles busy/done after reset want 0", bad);
    end
    wa_en = 1; wa_addr = 4; wa_data = 32'h44;
    step();
    idle_inputs();
    rd_addr = {5'd30, 5'd4};
    #1;
    tests++;
    if (rd_data[31:0] !== 32'h44 || rd_data[63:32] !== 32'h0) begin
      fails++; $display("FAIL post_abort: got %h want 0000000000000044", rd_data);
    end
  endtask

  initial begin
    idle_inputs();
    rd_addr = 0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    test_reset();
    test_write_bypass();
    test_port_conflict();
    test_scoreboard();
    test_sweep();
    test_sweep_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
